// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache sitting in
// the MEM-stage data-memory position, backed by a slow line-wide memory.
//
// Ports
//   clk_i, rst_i              clock (rising edge) and asynchronous active-low reset
//   cpu_req/cpu_we            access valid / 1 = store word, 0 = load word
//   cpu_addr/cpu_wdata        byte address (bits [1:0] ignored) / store data
//   cpu_rdata                 load data, valid when cpu_req & ~cpu_we & ~cpu_stall
//   cpu_stall                 pipeline freeze while a miss is being serviced
//   mem_req/mem_we            line request held until mem_ack / 1 = write-back, 0 = fetch
//   mem_addr                  line-aligned address (bits [4:0] = 0)
//   mem_wdata                 victim line for write-back
//   mem_rdata/mem_ack         fetched line / one-cycle completion pulse
//
// Line = 32 bytes = 8 words; word w sits at bits [32w+31:32w] of the line.
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [255:0]      mem_wdata,
  input  logic [255:0]      mem_rdata,
  input  logic              mem_ack
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - 5 - INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  // Miss line identity is captured at miss detection so the memory side stays
  // consistent even if the CPU drops its request mid-miss.
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]   miss_idx_q, miss_idx_d;

  // Tag and data storage carry no reset; valid bits gate their use.
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [255:0]         data_q [NUM_LINES];

  logic [2:0]           req_word_s;
  logic [INDEX_W-1:0]   req_idx_s;
  logic [TAG_W-1:0]     req_tag_s;
  logic                 hit_s;
  logic [INDEX_W-1:0]   victim_idx_s;
  logic [31:0]          rdata_s;
  logic                 stall_s;
  logic                 mem_req_s;
  logic                 mem_we_s;
  logic [ADDR_W-1:0]    mem_addr_s;
  logic                 line_we_s;
  logic                 word_we_s;
  logic                 unused_s;

  assign req_word_s = cpu_addr[4:2];
  assign req_idx_s  = cpu_addr[4+INDEX_W:5];
  assign req_tag_s  = cpu_addr[ADDR_W-1:5+INDEX_W];
  assign unused_s   = ^cpu_addr[1:0];

  assign hit_s = cpu_req & valid_q[req_idx_s] & (tag_q[req_idx_s] == req_tag_s);

  // Victim line selection: the requested index while idle, the latched one during a miss.
  always_comb begin
    if (state_q == ST_IDLE) begin
      victim_idx_s = req_idx_s;
    end else begin
      victim_idx_s = miss_idx_q;
    end
  end

  assign mem_wdata = data_q[victim_idx_s];

  // Next-state, array-control and output decode.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    rdata_s    = 32'd0;
    stall_s    = 1'b0;
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = {ADDR_W{1'b0}};
    line_we_s  = 1'b0;
    word_we_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (hit_s) begin
            if (cpu_we) begin
              word_we_s          = 1'b1;
              dirty_d[req_idx_s] = 1'b1;
            end else begin
              rdata_s = data_q[req_idx_s][{req_word_s, 5'b00000} +: 32];
            end
          end else begin
            stall_s    = 1'b1;
            miss_tag_d = req_tag_s;
            miss_idx_d = req_idx_s;
            if (valid_q[req_idx_s] & dirty_q[req_idx_s]) begin
              state_d = ST_WRITEBACK;
            end else begin
              state_d = ST_ALLOCATE;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        stall_s    = 1'b1;
        mem_req_s  = 1'b1;
        mem_we_s   = 1'b1;
        mem_addr_s = {tag_q[miss_idx_q], miss_idx_q, 5'b00000};
        if (mem_ack) begin
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = ST_ALLOCATE;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_ALLOCATE: begin
        stall_s    = 1'b1;
        mem_req_s  = 1'b1;
        mem_addr_s = {miss_tag_q, miss_idx_q, 5'b00000};
        if (mem_ack) begin
          line_we_s           = 1'b1;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = ST_IDLE;
        end else begin
          state_d = ST_ALLOCATE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted, even with a request pending.
  assign cpu_rdata = rst_i ? rdata_s    : 32'd0;
  assign cpu_stall = rst_i & stall_s;
  assign mem_req   = rst_i & mem_req_s;
  assign mem_we    = rst_i & mem_we_s;
  assign mem_addr  = rst_i ? mem_addr_s : {ADDR_W{1'b0}};

  // Control state: FSM, valid/dirty bits and latched miss line.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      valid_q    <= {NUM_LINES{1'b0}};
      dirty_q    <= {NUM_LINES{1'b0}};
      miss_tag_q <= {TAG_W{1'b0}};
      miss_idx_q <= {INDEX_W{1'b0}};
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  // Tag/data storage: full-line refill on allocate ack, single word on store hit.
  always_ff @(posedge clk_i) begin
    if (rst_i & line_we_s) begin
      data_q[miss_idx_q] <= mem_rdata;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (rst_i & word_we_s) begin
      data_q[req_idx_s][{req_word_s, 5'b00000} +: 32] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;

  int n_cmp = 0;
  int n_err = 0;

  // Results of the last access() call
  int           stalls;
  int           ntx;
  int           unstable;
  logic         done;
  logic [31:0]  got_rdata;
  logic         tx_we    [2];
  logic [31:0]  tx_addr  [2];
  logic [255:0] tx_wdata [2];

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.NUM_LINES(32), .ADDR_W(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) begin
      l[w*32 +: 32] = base + 32'(w);
    end
    return l;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request (called at posedge+1), act as backing memory with the
  // given ack latency, and run until cpu_stall is low. drop_at: stall count at
  // which cpu_req is withdrawn (-1 = never).
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input logic [255:0] line, input int drop_at);
    int cnt;
    int c;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    mem_rdata = line;
    stalls    = 0;
    ntx       = 0;
    unstable  = 0;
    done      = 1'b0;
    got_rdata = 32'd0;
    cnt       = 0;
    c         = 0;
    while (!done && c < 60) begin
      #1;
      if (!cpu_stall) begin
        done      = 1'b1;
        got_rdata = cpu_rdata;
      end else begin
        stalls++;
        if (mem_req) begin
          if (cnt == 0) begin
            if (ntx < 2) begin
              tx_we[ntx]    = mem_we;
              tx_addr[ntx]  = mem_addr;
              tx_wdata[ntx] = mem_wdata;
            end
            ntx++;
          end else if (ntx <= 2) begin
            if (mem_we !== tx_we[ntx-1] || mem_addr !== tx_addr[ntx-1]) unstable++;
          end
          cnt++;
          if (cnt == lat) begin
            mem_ack = 1'b1;
            cnt     = 0;
          end
        end
        if (stalls == drop_at) cpu_req = 1'b0;
      end
      @(posedge clk_i);
      #1;
      mem_ack = 1'b0;
      c++;
    end
    cpu_req = 1'b0;
    check("access_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    rst_i     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    mem_rdata = 256'd0;
    mem_ack   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_mem_req",   {63'd0, mem_req},   64'd0);
    check("rst_mem_we",    {63'd0, mem_we},    64'd0);
    check("rst_mem_addr",  {32'd0, mem_addr},  64'd0);
    check("rst_cpu_stall", {63'd0, cpu_stall}, 64'd0);
    check("rst_cpu_rdata", {32'd0, cpu_rdata}, 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("idle_stall", {63'd0, cpu_stall}, 64'd0);

    // 1) cold load 0x40, ack on the third cycle of mem_req
    access(1'b0, 32'h0000_0040, 32'd0, 3, mk_line(32'h1000_0000), -1);
    check("t1_stalls", 64'(stalls), 64'd4);
    check("t1_ntx",    64'(ntx),    64'd1);
    check("t1_we",     {63'd0, tx_we[0]},   64'd0);
    check("t1_addr",   {32'd0, tx_addr[0]}, 64'h40);
    check("t1_rdata",  {32'd0, got_rdata},  64'h1000_0000);
    check("t1_stable", 64'(unstable), 64'd0);

    // 2) store then load hit
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1, 256'd0, -1);
    check("t2_st_stalls", 64'(stalls), 64'd0);
    check("t2_st_ntx",    64'(ntx),    64'd0);
    access(1'b0, 32'h0000_0044, 32'd0, 1, 256'd0, -1);
    check("t2_ld_stalls", 64'(stalls), 64'd0);
    check("t2_ld_rdata",  {32'd0, got_rdata}, 64'hDEAD_BEEF);

    // 3) conflict miss on dirty line 2
    access(1'b0, 32'h0000_0444, 32'd0, 2, mk_line(32'h2000_0000), -1);
    check("t3_stalls",  64'(stalls), 64'd5);
    check("t3_ntx",     64'(ntx),    64'd2);
    check("t3_wb_we",   {63'd0, tx_we[0]},   64'd1);
    check("t3_wb_addr", {32'd0, tx_addr[0]}, 64'h40);
    check("t3_wb_w1",   {32'd0, tx_wdata[0][63:32]}, 64'hDEAD_BEEF);
    check("t3_wb_w0",   {32'd0, tx_wdata[0][31:0]},  64'h1000_0000);
    check("t3_rf_we",   {63'd0, tx_we[1]},   64'd0);
    check("t3_rf_addr", {32'd0, tx_addr[1]}, 64'h440);
    check("t3_rdata",   {32'd0, got_rdata},  64'h2000_0001);
    check("t3_stable",  64'(unstable), 64'd0);

    // 4) reset in ALLOCATE
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0000_0080;
    mem_rdata = mk_line(32'h4000_0000);
    #1;
    check("t4_miss_stall", {63'd0, cpu_stall}, 64'd1);
    @(posedge clk_i);
    #2;
    check("t4_alloc_req",  {63'd0, mem_req},  64'd1);
    check("t4_alloc_addr", {32'd0, mem_addr}, 64'h80);
    rst_i = 1'b0;
    #1;
    check("t4_rst_req",   {63'd0, mem_req},   64'd0);
    check("t4_rst_stall", {63'd0, cpu_stall}, 64'd0);
    check("t4_rst_addr",  {32'd0, mem_addr},  64'd0);
    check("t4_rst_rdata", {32'd0, cpu_rdata}, 64'd0);
    @(posedge clk_i);
    #1;
    cpu_req = 1'b0;
    rst_i   = 1'b1;
    access(1'b0, 32'h0000_0080, 32'd0, 1, mk_line(32'h4000_0000), -1);
    check("t4_re_ntx",    64'(ntx),    64'd1);
    check("t4_re_addr",   {32'd0, tx_addr[0]}, 64'h80);
    check("t4_re_stalls", 64'(stalls), 64'd2);
    check("t4_re_rdata",  {32'd0, got_rdata}, 64'h4000_0000);
    // line 2 was invalidated by reset: 0x444 misses cleanly
    access(1'b0, 32'h0000_0444, 32'd0, 1, mk_line(32'h2000_0000), -1);
    check("t4_inv_ntx",  64'(ntx), 64'd1);
    check("t4_inv_we",   {63'd0, tx_we[0]}, 64'd0);

    // 5) drop cpu_req during WRITEBACK
    access(1'b1, 32'h0000_0080, 32'h1234_5678, 1, 256'd0, -1);
    check("t5_st_stalls", 64'(stalls), 64'd0);
    access(1'b0, 32'h0000_0480, 32'd0, 2, mk_line(32'h3000_0000), 2);
    check("t5_stalls",  64'(stalls), 64'd5);
    check("t5_ntx",     64'(ntx),    64'd2);
    check("t5_wb_addr", {32'd0, tx_addr[0]}, 64'h80);
    check("t5_wb_w0",   {32'd0, tx_wdata[0][31:0]}, 64'h1234_5678);
    check("t5_rf_addr", {32'd0, tx_addr[1]}, 64'h480);
    check("t5_rdata",   {32'd0, got_rdata},  64'd0);
    check("t5_stable",  64'(unstable), 64'd0);
    access(1'b0, 32'h0000_0480, 32'd0, 1, 256'd0, -1);
    check("t5_hit_stalls", 64'(stalls), 64'd0);
    check("t5_hit_rdata",  {32'd0, got_rdata}, 64'h3000_0000);

    // 6) stray mem_ack while idle
    mem_rdata = {256{1'b1}};
    mem_ack   = 1'b1;
    #1;
    check("t6_req",   {63'd0, mem_req},   64'd0);
    check("t6_stall", {63'd0, cpu_stall}, 64'd0);
    @(posedge clk_i);
    #1;
    mem_ack = 1'b0;
    access(1'b0, 32'h0000_0484, 32'd0, 1, 256'd0, -1);
    check("t6_hit_stalls", 64'(stalls), 64'd0);
    check("t6_rdata_480",  {32'd0, got_rdata}, 64'h3000_0001);
    access(1'b0, 32'h0000_0444, 32'd0, 1, 256'd0, -1);
    check("t6_rdata_444",  {32'd0, got_rdata}, 64'h2000_0001);
    check("t6_ntx",        64'(ntx), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
